// File: rtl/count_display_mux_if.sv
// Display-side bundle for count_display_mux: load strobe/value in, segment/anode/frame out.
interface count_display_mux_if;
  logic       LOAD;
  logic [4:0] VAL;
  logic [6:0] SEG;
  logic [1:0] AN;
  logic       FRAME;

  modport master (
    output LOAD, VAL,
    input  SEG, AN, FRAME
  );

  modport slave (
    input  LOAD, VAL,
    output SEG, AN, FRAME
  );
endinterface

// File: rtl/count_display_mux.sv
// Two-digit multiplexed seven-segment driver with per-slot anti-ghosting blank interval.
// Optional macro LEADING_ZERO_BLANK_EN suppresses the tens digit when it is zero.
module count_display_mux #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  count_display_mux_if.slave  disp
);

  localparam int unsigned KW = $clog2(REFRESH_DIV);
  localparam logic [KW-1:0] KLast  = KW'(REFRESH_DIV - 1);
  localparam logic [KW-1:0] KBlank = KW'(BLANK_CYCLES);
  localparam logic [6:0] SegMask = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AnMask  = ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic {StBlank, StOn} phase_e;
  // With no blank interval a slot starts directly in the ON phase.
  localparam phase_e PhaseInit = (BLANK_CYCLES == 0) ? StOn : StBlank;

  phase_e        r_phase, w_phase_next;
  logic [KW-1:0] r_k, w_k_next;
  logic          r_slot, w_slot_next;
  logic [4:0]    r_pend, r_shown;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;
  logic          r_frame;

  logic          w_k_last;
  logic          w_frame_start;
  logic [4:0]    w_src;
  logic [4:0]    w_rem;
  logic [1:0]    w_tens;
  logic [3:0]    w_units;
  logic [6:0]    w_seg_act;
  logic [1:0]    w_an_act;
  logic          w_frame;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Phase FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_k     <= '0;
      r_slot  <= 1'b0;
      r_phase <= PhaseInit;
    end else begin
      r_k     <= w_k_next;
      r_slot  <= w_slot_next;
      r_phase <= w_phase_next;
    end
  end

  // Phase FSM: next state
  always_comb begin
    w_k_last     = (r_k == KLast);
    w_k_next     = w_k_last ? '0 : r_k + 1'b1;
    w_slot_next  = r_slot ^ w_k_last;
    w_phase_next = r_phase;
    if (w_k_last) begin
      w_phase_next = PhaseInit;
    end else if (w_k_next == KBlank) begin
      w_phase_next = StOn;
    end
  end

  assign w_frame_start = !r_slot && (r_k == '0);

  // Copy only at the frame start so a frame never mixes old and new digits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pend  <= '0;
      r_shown <= '0;
    end else begin
      if (w_frame_start) begin
        r_shown <= r_pend;
      end
      if (disp.LOAD) begin
        r_pend <= disp.VAL;
      end
    end
  end

  // The value being latched this cycle is already the one this frame displays.
  assign w_src = w_frame_start ? r_pend : r_shown;

  always_comb begin
    w_tens = 2'd0;
    w_rem  = w_src;
    if (w_src >= 5'd30) begin
      w_tens = 2'd3;
      w_rem  = w_src - 5'd30;
    end else if (w_src >= 5'd20) begin
      w_tens = 2'd2;
      w_rem  = w_src - 5'd20;
    end else if (w_src >= 5'd10) begin
      w_tens = 2'd1;
      w_rem  = w_src - 5'd10;
    end
    w_units = w_rem[3:0];
  end

  // Phase FSM: outputs (active-high here, polarity applied at the register)
  always_comb begin
    w_seg_act = 7'h00;
    w_an_act  = 2'b00;
    w_frame   = r_slot && w_k_last;
    if (r_phase == StOn) begin
      if (!r_slot) begin
        w_an_act  = 2'b01;
        w_seg_act = seg7(w_units);
      end else begin
        w_an_act  = 2'b10;
        w_seg_act = seg7({2'b00, w_tens});
`ifdef LEADING_ZERO_BLANK_EN
        if (w_tens == 2'd0) begin
          w_an_act  = 2'b00;
          w_seg_act = 7'h00;
        end
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_seg   <= SegMask;
      r_an    <= AnMask;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_seg_act ^ SegMask;
      r_an    <= w_an_act ^ AnMask;
      r_frame <= w_frame;
    end
  end

  assign disp.SEG   = r_seg;
  assign disp.AN    = r_an;
  assign disp.FRAME = r_frame;

endmodule
